// File: rtl/turf_dm_pkg.sv
// turf_dm_pkg: field layout shared by the S2MM buffer-ring logic.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
// Contents: S2MM command offsets (72-bit word), S2MM status offsets, the
// 32-bit event control word layout and the flag-bit enum for that word.
package turf_dm_pkg;

  // S2MM command word
  localparam int CMD_W        = 72;
  localparam int CMD_TAG_LSB  = 64;
  localparam int CMD_TAG_W    = 4;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_ADDR_W   = 32;
  localparam int CMD_DRR_BIT  = 31;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_DSA_LSB  = 24;
  localparam int CMD_DSA_W    = 6;
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_BTT_LSB  = 0;
  localparam int CMD_BTT_W    = 23;

  // S2MM status word (indeterminate-BTT mode)
  localparam int STS_W          = 32;
  localparam int STS_EOP_BIT    = 31;
  localparam int STS_BYTES_LSB  = 8;
  localparam int STS_BYTES_W    = 23;
  localparam int STS_OKAY_BIT   = 7;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_TAG_LSB    = 0;
  localparam int STS_TAG_W      = 4;

  // Event control word towards the fragment generator
  localparam int CTRL_W       = 32;
  localparam int CTRL_IDX_LSB = 24;
  localparam int CTRL_IDX_W   = 8;
  localparam int CTRL_FLG_LSB = 20;
  localparam int CTRL_FLG_W   = 4;
  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_LEN_W   = 20;

  // Bit positions inside the 4-bit flag field of the control word
  typedef enum logic [1:0] {
    FLG_NEOP   = 2'd0,  // frame overflowed the buffer, continuation follows
    FLG_SLVERR = 2'd1,
    FLG_DECERR = 2'd2,
    FLG_INTERR = 2'd3
  } ctrl_flag_e;

  function automatic logic [CTRL_FLG_W-1:0] sts_flags(
    input logic eop,
    input logic slverr,
    input logic decerr,
    input logic interr
  );
    logic [CTRL_FLG_W-1:0] f;
    f             = '0;
    f[FLG_NEOP]   = ~eop;
    f[FLG_SLVERR] = slverr;
    f[FLG_DECERR] = decerr;
    f[FLG_INTERR] = interr;
    return f;
  endfunction

endpackage

// File: rtl/turf_s2mm_buf_ctrl.sv
// turf_s2mm_buf_ctrl: buffer-ring manager between S2MM DataMover and turf_fragment_gen.
// Latency: status accept -> m_ctrl valid 1 cycle; free -> next cmd valid 2 cycles when full.
// Backpressure: m_ctrl is a 1-deep no-bubble register; s_sts stalls while it is held.
// Ports: aclk/aresetn (sync, active-low); run gates new commands; m_cmd_* 72-bit S2MM
// command stream; s_sts_* 32-bit S2MM status stream; m_ctrl_* 32-bit event control word;
// s_free_* in-order buffer release; buffers_free credit count; tag_err/free_err sticky.
module turf_s2mm_buf_ctrl
  import turf_dm_pkg::*;
#(
  parameter int          NBUF          = 16,
  parameter logic [31:0] BUF_BASE      = 32'h0,
  parameter int          BUF_SIZE_LOG2 = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             run,
  output logic [CMD_W-1:0] m_cmd_tdata,
  output logic             m_cmd_tvalid,
  input  logic             m_cmd_tready,
  input  logic [STS_W-1:0] s_sts_tdata,
  input  logic             s_sts_tvalid,
  output logic             s_sts_tready,
  output logic [CTRL_W-1:0] m_ctrl_tdata,
  output logic             m_ctrl_tvalid,
  input  logic             m_ctrl_tready,
  input  logic [7:0]       s_free_tdata,
  input  logic             s_free_tvalid,
  output logic             s_free_tready,
  output logic [4:0]       buffers_free,
  output logic             tag_err,
  output logic             free_err
);

  localparam int AW = (NBUF > 1) ? $clog2(NBUF) : 1;
  // One extra pointer bit distinguishes full from empty.
  localparam int PW = AW + 1;

  logic [PW-1:0] cmd_ptr_q,  cmd_ptr_d;
  logic [PW-1:0] sts_ptr_q,  sts_ptr_d;
  logic [PW-1:0] free_ptr_q, free_ptr_d;
  logic              cmd_vld_q,  cmd_vld_d;
  logic [CMD_W-1:0]  cmd_dat_q,  cmd_dat_d;
  logic              ctrl_vld_q, ctrl_vld_d;
  logic [CTRL_W-1:0] ctrl_dat_q, ctrl_dat_d;
  logic tag_err_q,  tag_err_d;
  logic free_err_q, free_err_d;

  logic [AW-1:0] cmd_idx, sts_idx, free_idx;
  logic [PW-1:0] used_cnt;
  logic          full;
  logic          cmd_hs, sts_hs, free_hs;
  logic          sts_pending, free_pending;

  // Status bits carried only for completeness of the interface.
  logic unused_sts;
  assign unused_sts = &{1'b0, s_sts_tdata[STS_OKAY_BIT],
                        s_sts_tdata[STS_BYTES_LSB+CTRL_LEN_W +: STS_BYTES_W-CTRL_LEN_W]};

  assign cmd_idx  = cmd_ptr_q[AW-1:0];
  assign sts_idx  = sts_ptr_q[AW-1:0];
  assign free_idx = free_ptr_q[AW-1:0];

  // Occupancy from registered pointers only; a same-cycle free shows up a cycle late.
  assign used_cnt = cmd_ptr_q - free_ptr_q;
  assign full     = (used_cnt == PW'(NBUF));

  // A status can only belong to a command the DataMover has accepted.
  assign sts_pending  = (sts_ptr_q != cmd_ptr_q);
  assign free_pending = (free_ptr_q != sts_ptr_q);

  assign s_sts_tready  = sts_pending && (!ctrl_vld_q || m_ctrl_tready);
  assign s_free_tready = free_pending;

  assign cmd_hs  = cmd_vld_q && m_cmd_tready;
  assign sts_hs  = s_sts_tvalid && s_sts_tready;
  assign free_hs = s_free_tvalid && free_pending;

  always_comb begin
    cmd_ptr_d  = cmd_ptr_q;
    sts_ptr_d  = sts_ptr_q;
    free_ptr_d = free_ptr_q;
    cmd_vld_d  = cmd_vld_q;
    cmd_dat_d  = cmd_dat_q;
    ctrl_vld_d = ctrl_vld_q;
    ctrl_dat_d = ctrl_dat_q;
    tag_err_d  = tag_err_q;
    free_err_d = free_err_q;

    // Command issue: a new word is only built while the slot is empty, so the
    // issue/handshake cycles alternate and a pending command ignores run.
    if (cmd_hs) begin
      cmd_vld_d = 1'b0;
      cmd_ptr_d = cmd_ptr_q + PW'(1);
    end else if (!cmd_vld_q && run && !full) begin
      cmd_vld_d = 1'b1;
      cmd_dat_d = '0;
      cmd_dat_d[CMD_TAG_LSB +: CMD_TAG_W]   = CMD_TAG_W'(cmd_idx);
      cmd_dat_d[CMD_ADDR_LSB +: CMD_ADDR_W] = BUF_BASE + (32'(cmd_idx) << BUF_SIZE_LOG2);
      cmd_dat_d[CMD_DRR_BIT]                = 1'b0;
      cmd_dat_d[CMD_EOF_BIT]                = 1'b1;
      cmd_dat_d[CMD_DSA_LSB +: CMD_DSA_W]   = '0;
      cmd_dat_d[CMD_TYPE_BIT]               = 1'b1;
      cmd_dat_d[CMD_BTT_LSB +: CMD_BTT_W]   = CMD_BTT_W'(32'd1 << BUF_SIZE_LOG2);
    end

    // Control output register: drain first, then a fresh load overrides it so
    // accept + drain in the same cycle keeps valid high with the new word.
    if (ctrl_vld_q && m_ctrl_tready) begin
      ctrl_vld_d = 1'b0;
    end
    if (sts_hs) begin
      ctrl_vld_d = 1'b1;
      ctrl_dat_d = '0;
      // Index comes from our own pointer, not the returned tag.
      ctrl_dat_d[CTRL_IDX_LSB +: CTRL_IDX_W] = CTRL_IDX_W'(sts_idx);
      ctrl_dat_d[CTRL_FLG_LSB +: CTRL_FLG_W] = sts_flags(s_sts_tdata[STS_EOP_BIT],
                                                         s_sts_tdata[STS_SLVERR_BIT],
                                                         s_sts_tdata[STS_DECERR_BIT],
                                                         s_sts_tdata[STS_INTERR_BIT]);
      ctrl_dat_d[CTRL_LEN_LSB +: CTRL_LEN_W] = s_sts_tdata[STS_BYTES_LSB +: CTRL_LEN_W];
      sts_ptr_d = sts_ptr_q + PW'(1);
      if (s_sts_tdata[STS_TAG_LSB +: STS_TAG_W] != STS_TAG_W'(sts_idx)) begin
        tag_err_d = 1'b1;
      end
    end

    // Release must be in order; a mismatch is flagged but the ring keeps moving.
    if (free_hs) begin
      free_ptr_d = free_ptr_q + PW'(1);
      if (s_free_tdata != 8'(free_idx)) begin
        free_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cmd_ptr_q  <= '0;
      sts_ptr_q  <= '0;
      free_ptr_q <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_dat_q  <= '0;
      ctrl_vld_q <= 1'b0;
      ctrl_dat_q <= '0;
      tag_err_q  <= 1'b0;
      free_err_q <= 1'b0;
    end else begin
      cmd_ptr_q  <= cmd_ptr_d;
      sts_ptr_q  <= sts_ptr_d;
      free_ptr_q <= free_ptr_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_dat_q  <= cmd_dat_d;
      ctrl_vld_q <= ctrl_vld_d;
      ctrl_dat_q <= ctrl_dat_d;
      tag_err_q  <= tag_err_d;
      free_err_q <= free_err_d;
    end
  end

  assign m_cmd_tdata   = cmd_dat_q;
  assign m_cmd_tvalid  = cmd_vld_q;
  assign m_ctrl_tdata  = ctrl_dat_q;
  assign m_ctrl_tvalid = ctrl_vld_q;
  assign buffers_free  = 5'(NBUF) - 5'(used_cnt);
  assign tag_err       = tag_err_q;
  assign free_err      = free_err_q;

endmodule
